// File: rtl/neuron_mac_unit.sv
// neuron_mac_unit
//   Multiply-accumulate stage for one neuron. After a start pulse it accepts N_INPUTS
//   (weight, activation) pairs and accumulates their products. It then rescales the sum
//   by 2^-FRAC_BITS, saturates it to DATA_W bits and presents one result byte together
//   with the neuron-memory write address that arrived with the last pair.
//
//   Optional feature: define NEURON_MAC_RELU_EN to apply ReLU after saturation.
//   Without it the activation is linear.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          single-cycle pulse that begins a neuron (only honoured in idle)
//   in_valid       weight_data / neuro_data / in_write_addr valid this cycle
//   weight_data    signed weight
//   neuro_data     signed input activation
//   in_write_addr  destination address, latched with the last pair
//   busy           high from start acceptance until out_valid
//   out_valid      single-cycle result strobe
//   out_data       signed result, held until the next result
//   out_addr       write address for out_data, held until the next result
//   sat            result was clipped, qualified by out_valid

module neuron_mac_unit #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned ACC_W     = 24,
   parameter int unsigned N_INPUTS  = 16,
   parameter int unsigned FRAC_BITS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] weight_data,
   input  logic [DATA_W-1:0] neuro_data,
   input  logic [ADDR_W-1:0] in_write_addr,
   output logic              busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              sat
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned CNT_W  = $clog2(N_INPUTS + 1);
   localparam int          MaxInt = 2 ** (DATA_W - 1) - 1;
   localparam int          MinInt = -(2 ** (DATA_W - 1));
   localparam logic signed [ACC_W-1:0] AccMax = ACC_W'(MaxInt);
   localparam logic signed [ACC_W-1:0] AccMin = ACC_W'(MinInt);
   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_INPUTS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDrain,
      StOutput
   } state_e;

   state_e                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [PROD_W-1:0]  prod_q, prod_d;
   logic                      prod_vld_q, prod_vld_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic                      out_valid_q, out_valid_d;
   logic [DATA_W-1:0]         out_data_q, out_data_d;
   logic [ADDR_W-1:0]         out_addr_q, out_addr_d;
   logic                      sat_q, sat_d;

   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc_shift;
   logic [DATA_W-1:0]         res_clip;
   logic [DATA_W-1:0]         res_act;
   logic                      res_sat;

   assign prod_ext  = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
   // Arithmetic shift on a signed operand rounds toward minus infinity.
   assign acc_shift = acc_q >>> FRAC_BITS;

   always_comb begin
      res_sat  = 1'b0;
      res_clip = acc_shift[DATA_W-1:0];
      if (acc_shift > AccMax) begin
         res_sat  = 1'b1;
         res_clip = {1'b0, {(DATA_W - 1){1'b1}}};
      end else if (acc_shift < AccMin) begin
         res_sat  = 1'b1;
         res_clip = {1'b1, {(DATA_W - 1){1'b0}}};
      end
   end

`ifdef NEURON_MAC_RELU_EN
   assign res_act = res_clip[DATA_W-1] ? '0 : res_clip;
`else
   assign res_act = res_clip;
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      prod_d      = prod_q;
      prod_vld_d  = 1'b0;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      sat_d       = sat_q;

      // Second pipeline stage: fold the product registered on the previous edge.
      if (prod_vld_q) begin
         acc_d = acc_q + prod_ext;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            if (in_valid) begin
               prod_d     = $signed(weight_data) * $signed(neuro_data);
               prod_vld_d = 1'b1;
               cnt_d      = cnt_q + CNT_W'(1);
               if (cnt_q == LastIdx) begin
                  addr_d  = in_write_addr;
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            state_d = StOutput;
         end
         StOutput: begin
            out_valid_d = 1'b1;
            out_data_d  = res_act;
            out_addr_d  = addr_q;
            sat_d       = res_sat;
            state_d     = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         prod_q      <= '0;
         prod_vld_q  <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         prod_q      <= prod_d;
         prod_vld_q  <= prod_vld_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         sat_q       <= sat_d;
      end
   end

   // busy falls on the same edge that raises out_valid, since that edge returns to idle.
   assign busy      = (state_q != StIdle);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Testbench for neuron_mac_unit: directed cases plus randomized neurons. The driver pushes
// the expected result (from a plain-arithmetic model) into a queue; a monitor pops and
// compares on every out_valid.

module tb_neuron_mac_unit;

   localparam int N = 16;

   typedef struct {
      logic [7:0] data;
      logic [7:0] addr;
      logic       sat;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] weight_data = '0;
   logic [7:0] neuro_data = '0;
   logic [7:0] in_write_addr = '0;
   logic       busy;
   logic       out_valid;
   logic [7:0] out_data;
   logic [7:0] out_addr;
   logic       sat;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t exp_q[$];
   logic signed [7:0] ws[N];
   logic signed [7:0] xs[N];

   neuron_mac_unit #(
      .DATA_W   (8),
      .ADDR_W   (8),
      .ACC_W    (24),
      .N_INPUTS (N),
      .FRAC_BITS(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .weight_data  (weight_data),
      .neuro_data   (neuro_data),
      .in_write_addr(in_write_addr),
      .busy         (busy),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_addr     (out_addr),
      .sat          (sat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: exact integer dot product, floor-divide by 16, clip to int8, optional ReLU.
   function automatic exp_t model(input logic [7:0] addr, input int due);
      exp_t e;
      int   sum = 0;
      int   r;
      for (int i = 0; i < N; i++) sum += int'(ws[i]) * int'(xs[i]);
      r = sum >>> 4;
      e.sat = 1'b0;
      if (r > 127) begin
         r = 127;
         e.sat = 1'b1;
      end else if (r < -128) begin
         r = -128;
         e.sat = 1'b1;
      end
`ifdef NEURON_MAC_RELU_EN
      if (r < 0) r = 0;
`endif
      e.data = 8'(r);
      e.addr = addr;
      e.cyc  = due;
      return e;
   endfunction

   always @(negedge clk) begin
      if (reset && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_addr", 32'(out_addr), 32'(e.addr));
            check("sat", 32'(sat), 32'(e.sat));
            check("latency_cycle", 32'(cyc), 32'(e.cyc));
            check("busy_at_out_valid", 32'(busy), 32'd0);
         end
      end
   end

   // Runs one neuron using ws/xs. gap_mode: 0 none, 1 every other cycle, 2 random.
   task automatic run_neuron(input logic [7:0] addr, input int gap_mode, input bit mid_start,
                             input bit junk_after);
      exp_t e;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      for (int i = 0; i < N; i++) begin
         int gaps;
         gaps = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? $urandom_range(0, 2) : 0);
         for (int g = 0; g < gaps; g++) begin
            in_valid    = 1'b0;
            weight_data = 8'($urandom);
            neuro_data  = 8'($urandom);
            start       = (mid_start && i == N / 2 && g == 0);
            @(posedge clk); #1;
            start = 1'b0;
         end
         in_valid      = 1'b1;
         weight_data   = ws[i];
         neuro_data    = xs[i];
         in_write_addr = (i == N - 1) ? addr : 8'($urandom);
         if (i == N - 1) begin
            e = model(addr, cyc + 3);
            exp_q.push_back(e);
         end
         @(posedge clk); #1;
      end
      // Pairs offered after the last one must be ignored.
      in_valid      = junk_after;
      weight_data   = 8'($urandom);
      neuro_data    = 8'($urandom);
      in_write_addr = 8'($urandom);
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("hold_out_data", 32'(out_data), 32'(e.data));
      check("hold_out_addr", 32'(out_addr), 32'(e.addr));
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic fill(input int w, input int x);
      for (int i = 0; i < N; i++) begin
         ws[i] = 8'(w);
         xs[i] = 8'(x);
      end
   endtask

   initial begin
      repeat (10) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_addr", 32'(out_addr), 32'd0);
      check("rst_sat", 32'(sat), 32'd0);
      reset = 1'b1;

      // in_valid without start must produce nothing (monitor flags any out_valid).
      for (int i = 0; i < 20; i++) begin
         in_valid    = i[0];
         weight_data = 8'($urandom);
         neuro_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("no_start_busy", 32'(busy), 32'd0);

      fill(1, 16);
      run_neuron(8'h25, 0, 1'b0, 1'b0);
      fill(16, 16);
      run_neuron(8'h3a, 0, 1'b0, 1'b1);
      fill(-16, 16);
      run_neuron(8'h41, 0, 1'b0, 1'b0);
      fill(2, 8);
      run_neuron(8'h77, 1, 1'b1, 1'b0);

      // Reset in the middle of a neuron aborts it.
      fill(100, 100);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid    = 1'b1;
         weight_data = ws[i];
         neuro_data  = xs[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      reset    = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("midrst_no_output", 32'(exp_q.size()), 32'd0);
      fill(1, 16);
      run_neuron(8'h10, 0, 1'b0, 1'b0);

      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < N; i++) begin
            ws[i] = 8'($urandom);
            xs[i] = (n < 5) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         end
         run_neuron(8'($urandom), 2, n[0], n[1]);
      end

      repeat (10) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
